// File: rtl/serial_cfg_master.sv
// serial_cfg_master: serialises a {Rate, PR} configuration byte onto SCL/SDA.
// Frame is START, 8 data bits MSB-first, ACK slot, STOP, then a forced idle gap.
// A NACK triggers up to MAX_RETRY further attempts with the same byte.
module serial_cfg_master #(
    parameter int unsigned HALF      = 2,
    parameter int unsigned GAP       = 8,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [3:0] PR,
    input  logic [2:0] Rate,
    output logic       SCL,
    output logic       SDA_Out,
    output logic       SDA_Enable,
    input  logic       SDA_In,
    output logic       busy,
    output logic       done,
    output logic       ack_ok
);

    localparam int unsigned CntMax = (2 * HALF > GAP) ? 2 * HALF : GAP;
    localparam int unsigned CW     = $clog2(CntMax);
    localparam int unsigned RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] CntHalfM1 = CW'(HALF - 1);
    localparam logic [CW-1:0] CntHalf   = CW'(HALF);
    localparam logic [CW-1:0] CntQuart  = CW'(HALF / 2);
    localparam logic [CW-1:0] CntSample = CW'(HALF + HALF / 2);
    localparam logic [CW-1:0] CntEnd    = CW'(2 * HALF - 1);
    localparam logic [CW-1:0] CntGapEnd = CW'(GAP - 1);
    localparam logic [RW-1:0] RetryMax  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {StIdle, StStart, StBit, StAck, StStop, StHold} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [7:0]      frame_q, frame_d;
    logic            acked_q, acked_d;
    logic            done_q, done_d;
    logic            ack_ok_q, ack_ok_d;
    logic            scl_q, scl_d;
    logic            sda_q, sda_d;
    logic            en_q, en_d;

    // Ready is withheld during the done cycle so a new accept never coincides with done.
    assign cfg_ready  = (state_q == StIdle) && !done_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign ack_ok     = ack_ok_q;
    assign SCL        = scl_q;
    assign SDA_Out    = sda_q;
    assign SDA_Enable = en_q;

    // Next-state: slot counter, bit index, ACK sampling and retry decision.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        retry_d  = retry_q;
        frame_d  = frame_q;
        acked_d  = acked_q;
        done_d   = 1'b0;
        ack_ok_d = ack_ok_q;
        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                retry_d = '0;
                if (cfg_valid && cfg_ready) begin
                    state_d = StStart;
                    frame_d = {1'b0, Rate, PR};
                end
            end
            StStart: begin
                if (cnt_q == CntHalfM1) begin
                    state_d = StBit;
                    cnt_d   = '0;
                    idx_d   = 3'd7;
                end
            end
            StBit: begin
                if (cnt_q == CntEnd) begin
                    cnt_d = '0;
                    if (idx_q == 3'd0) begin
                        state_d = StAck;
                    end else begin
                        idx_d = idx_q - 3'd1;
                    end
                end
            end
            StAck: begin
                // Anything but a clean low (including X/Z) counts as NACK.
                if (cnt_q == CntSample) begin
                    acked_d = (SDA_In == 1'b0) ? 1'b1 : 1'b0;
                end
                if (cnt_q == CntEnd) begin
                    state_d = StStop;
                    cnt_d   = '0;
                end
            end
            StStop: begin
                if (cnt_q == CntEnd) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                if (cnt_q == CntGapEnd) begin
                    cnt_d = '0;
                    if (acked_q) begin
                        state_d  = StIdle;
                        done_d   = 1'b1;
                        ack_ok_d = 1'b1;
                    end else if (retry_q < RetryMax) begin
                        state_d = StStart;
                        retry_d = retry_q + 1'b1;
                    end else begin
                        state_d  = StIdle;
                        done_d   = 1'b1;
                        ack_ok_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus pin values for the upcoming cycle, derived from the next state so the pins are registered.
    always_comb begin
        scl_d = 1'b1;
        sda_d = sda_q;
        en_d  = en_q;
        unique case (state_d)
            StStart: begin
                sda_d = 1'b0;
                en_d  = 1'b0;
            end
            StBit: begin
                scl_d = (cnt_d >= CntHalf);
                en_d  = 1'b0;
                if (cnt_d == CntQuart) sda_d = frame_d[idx_d];
            end
            StAck: begin
                scl_d = (cnt_d >= CntHalf);
                if (cnt_d == CntQuart) en_d = 1'b1;
            end
            StStop: begin
                scl_d = (cnt_d >= CntHalf);
                if (cnt_d == CntQuart) begin
                    en_d  = 1'b0;
                    sda_d = 1'b0;
                end
            end
            default: begin
                sda_d = 1'b1;
                en_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; asynchronous reset returns the bus to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= 3'd7;
            retry_q  <= '0;
            frame_q  <= 8'h00;
            acked_q  <= 1'b0;
            done_q   <= 1'b0;
            ack_ok_q <= 1'b0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            frame_q  <= frame_d;
            acked_q  <= acked_d;
            done_q   <= done_d;
            ack_ok_q <= ack_ok_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
            en_q     <= en_d;
        end
    end

endmodule
